// File: rtl/lsb_ring.sv
// lsb_ring: in-order load/store ring buffer with operand capture and one outstanding memory request.
// Loads leave the head as soon as their operands are ready; stores wait until they are the ROB head.
module lsb_ring #(
    parameter int LSB_BIT = 3,
    parameter int ROB_BIT = 4,
    parameter int XLEN    = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               issue_valid,
    input  logic               issue_is_load,
    input  logic [2:0]         issue_funct3,
    input  logic [XLEN-1:0]    issue_imm,
    input  logic [XLEN-1:0]    issue_v1,
    input  logic [XLEN-1:0]    issue_v2,
    input  logic               issue_q1_busy,
    input  logic               issue_q2_busy,
    input  logic [ROB_BIT-1:0] issue_q1,
    input  logic [ROB_BIT-1:0] issue_q2,
    input  logic [ROB_BIT-1:0] issue_rob,
    output logic               full_out,
    output logic [LSB_BIT:0]   count_out,
    input  logic               cdb_valid,
    input  logic [ROB_BIT-1:0] cdb_rob,
    input  logic [XLEN-1:0]    cdb_value,
    input  logic [ROB_BIT-1:0] rob_head,
    input  logic               rob_empty,
    output logic               mem_req,
    output logic               mem_we,
    output logic [1:0]         mem_size,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic               mem_done,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               out_valid,
    output logic [ROB_BIT-1:0] out_rob,
    output logic [XLEN-1:0]    out_value
);
    localparam int DEPTH = 1 << LSB_BIT;
    logic [DEPTH-1:0]   busy, is_load, q1b, q2b;
    logic [2:0]         funct3 [DEPTH];
    logic [XLEN-1:0]    imm [DEPTH], v1 [DEPTH], v2 [DEPTH];
    logic [ROB_BIT-1:0] q1 [DEPTH], q2 [DEPTH], rob [DEPTH];
    logic [LSB_BIT-1:0] head, tail;
    logic [LSB_BIT:0]   count;
    logic               req_silent, req_load, out_load;
    logic [2:0]         req_funct3;
    logic [ROB_BIT-1:0] req_rob;
    logic [XLEN:0]      w1 [DEPTH], w2 [DEPTH];
    logic [XLEN:0]      i1, i2;
    logic [XLEN-1:0]    ext;
    logic               enq, deq, done;
    // Returns {still_pending, value} after snooping both broadcast buses.
    function automatic logic [XLEN:0] fwd(input logic pend, input logic [ROB_BIT-1:0] tag,
                                          input logic [XLEN-1:0] val);
        if (pend && cdb_valid && cdb_rob == tag) return {1'b0, cdb_value};
        if (pend && out_valid && out_load && out_rob == tag) return {1'b0, out_value};
        return {pend, val};
    endfunction
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = fwd(q1b[i], q1[i], v1[i]);
            w2[i] = fwd(q2b[i], q2[i], v2[i]);
        end
    end
    assign i1        = fwd(issue_q1_busy, issue_q1, issue_v1);
    assign i2        = fwd(issue_q2_busy, issue_q2, issue_v2);
    assign count_out = count;
    assign full_out  = count >= (LSB_BIT+1)'(DEPTH - 1);
    assign enq  = rdy_in && !flush_in && issue_valid && count != (LSB_BIT+1)'(DEPTH);
    assign done = rdy_in && mem_req && mem_done;
    // Head may use operands arriving this very cycle, so a woken head dispatches without delay.
    assign deq  = rdy_in && !flush_in && !mem_req && busy[head] && !w1[head][XLEN] && !w2[head][XLEN]
                  && (is_load[head] || (rob_head == rob[head] && !rob_empty));
    assign ext  = !req_load ? '0 :
                  req_funct3[1:0] == 2'd0 ? {{(XLEN-8){!req_funct3[2] && mem_rdata[7]}}, mem_rdata[7:0]} :
                  req_funct3[1:0] == 2'd1 ? {{(XLEN-16){!req_funct3[2] && mem_rdata[15]}}, mem_rdata[15:0]} :
                  mem_rdata;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy    <= '0;
            is_load <= '0;
            q1b     <= '0;
            q2b     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                funct3[i] <= '0;
                imm[i]    <= '0;
                v1[i]     <= '0;
                v2[i]     <= '0;
                q1[i]     <= '0;
                q2[i]     <= '0;
                rob[i]    <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_size   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            out_valid  <= 1'b0;
            out_rob    <= '0;
            out_value  <= '0;
            out_load   <= 1'b0;
            req_silent <= 1'b0;
            req_load   <= 1'b0;
            req_funct3 <= '0;
            req_rob    <= '0;
        end else if (rdy_in) begin
            out_valid <= 1'b0;
            if (done) begin
                mem_req   <= 1'b0;
                out_valid <= !(req_silent || flush_in);
                out_rob   <= req_rob;
                out_value <= ext;
                out_load  <= req_load;
            end
            // Memory cannot abort, so a flushed request finishes but its result is dropped.
            if (flush_in) begin
                busy       <= '0;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                req_silent <= mem_req && !done;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    q1b[i] <= w1[i][XLEN];
                    v1[i]  <= w1[i][XLEN-1:0];
                    q2b[i] <= w2[i][XLEN];
                    v2[i]  <= w2[i][XLEN-1:0];
                end
                if (enq) begin
                    busy[tail]    <= 1'b1;
                    is_load[tail] <= issue_is_load;
                    funct3[tail]  <= issue_funct3;
                    imm[tail]     <= issue_imm;
                    rob[tail]     <= issue_rob;
                    q1[tail]      <= issue_q1;
                    q2[tail]      <= issue_q2;
                    q1b[tail]     <= i1[XLEN];
                    v1[tail]      <= i1[XLEN-1:0];
                    q2b[tail]     <= i2[XLEN];
                    v2[tail]      <= i2[XLEN-1:0];
                    tail          <= tail + 1'b1;
                end
                if (deq) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                    mem_req    <= 1'b1;
                    mem_we     <= !is_load[head];
                    mem_addr   <= w1[head][XLEN-1:0] + imm[head];
                    mem_wdata  <= w2[head][XLEN-1:0];
                    mem_size   <= funct3[head][1:0];
                    req_rob    <= rob[head];
                    req_funct3 <= funct3[head];
                    req_load   <= is_load[head];
                    req_silent <= 1'b0;
                end
                count <= count + (LSB_BIT+1)'(enq) - (LSB_BIT+1)'(deq);
            end
        end
    end
endmodule

// File: tb/tb_lsb_ring.sv
// tb_lsb_ring: directed scenarios plus a randomized run against a queue-based reference model.
module tb_lsb_ring;
    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  rob;
    } item_t;
    logic        clk_in = 0, rst_in = 0, rdy_in = 1, flush_in = 0;
    logic        issue_valid = 0, issue_is_load = 0, issue_q1_busy = 0, issue_q2_busy = 0;
    logic [2:0]  issue_funct3 = 0;
    logic [31:0] issue_imm = 0, issue_v1 = 0, issue_v2 = 0;
    logic [3:0]  issue_q1 = 0, issue_q2 = 0, issue_rob = 0;
    logic        full_out;
    logic [2:0]  count_out;
    logic        cdb_valid = 0;
    logic [3:0]  cdb_rob = 0, rob_head = 0;
    logic [31:0] cdb_value = 0;
    logic        rob_empty = 1;
    logic        mem_req, mem_we, mem_done = 0;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic        out_valid;
    logic [3:0]  out_rob;
    logic [31:0] out_value;
    int          total = 0, bad = 0;
    int          lf3 [5] = '{0, 1, 2, 4, 5};
    item_t       pend [$];
    item_t       cur, nxt;
    logic        outst, drv_done, drv_enq, drv_rdy, disp_exp, exp_ov;
    logic [3:0]  exp_rob;
    logic [31:0] exp_val, v1r, immr;

    lsb_ring #(.LSB_BIT(2), .ROB_BIT(4), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_funct3(issue_funct3),
        .issue_imm(issue_imm), .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
        .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_rob(issue_rob),
        .full_out(full_out), .count_out(count_out),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .rob_head(rob_head), .rob_empty(rob_empty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic put(input logic ld, input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] v1,
                       input logic [31:0] v2, input logic b1, input logic [3:0] t1, input logic [3:0] rob);
        issue_valid = 1; issue_is_load = ld; issue_funct3 = f3; issue_imm = imm;
        issue_v1 = v1; issue_v2 = v2; issue_q1_busy = b1; issue_q1 = t1;
        issue_q2_busy = 0; issue_q2 = 0; issue_rob = rob;
    endtask

    task automatic enq(input logic ld, input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] v1,
                       input logic [31:0] v2, input logic b1, input logic [3:0] t1, input logic [3:0] rob);
        put(ld, f3, imm, v1, v2, b1, t1, rob);
        step();
        issue_valid = 0; issue_q1_busy = 0;
    endtask

    task automatic wait_req(input string tag);
        for (int n = 0; n < 20 && !mem_req; n++) step();
        chk(tag, mem_req, 1);
    endtask

    task automatic resp(input logic [31:0] rd);
        mem_done = 1; mem_rdata = rd;
        step();
        mem_done = 0;
    endtask

    // Load result from the ISA definition of each width/sign code, using plain integer arithmetic.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] rd);
        int unsigned b, h;
        b = rd % 256;
        h = rd % 65536;
        case (f3)
            3'd0:    return b >= 128 ? b - 256 : b;
            3'd1:    return h >= 32768 ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    initial begin
        #1 rst_in = 1;
        #1;
        chk("rst_count", count_out, 0);
        chk("rst_full", full_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_ov", out_valid, 0);
        step(); step();
        rst_in = 0;
        // LB with negative offset
        enq(1, 3'd0, 32'hFFFFFFFC, 32'h1000, 0, 0, 0, 4'd1);
        chk("lb_early", mem_req, 0);
        chk("lb_cnt1", count_out, 1);
        step();
        chk("lb_req", mem_req, 1);
        chk("lb_addr", mem_addr, 32'h00000FFC);
        chk("lb_size", mem_size, 0);
        chk("lb_we", mem_we, 0);
        chk("lb_cnt0", count_out, 0);
        resp(32'h000000F0);
        chk("lb_reqlo", mem_req, 0);
        chk("lb_ov", out_valid, 1);
        chk("lb_rob", out_rob, 1);
        chk("lb_val", out_value, 32'hFFFFFFF0);
        step();
        chk("lb_pulse", out_valid, 0);
        // LBU
        enq(1, 3'd4, 32'hFFFFFFFC, 32'h1000, 0, 0, 0, 4'd2);
        wait_req("lbu_req");
        chk("lbu_addr", mem_addr, 32'h00000FFC);
        resp(32'h000000F0);
        chk("lbu_val", out_value, 32'h000000F0);
        step();
        // store waits for ROB head
        rob_empty = 0; rob_head = 3;
        enq(0, 3'd2, 32'h8, 32'h200, 32'hDEADBEEF, 0, 0, 4'd5);
        step(); step(); step();
        chk("st_gate", mem_req, 0);
        chk("st_cnt", count_out, 1);
        rob_head = 5;
        step();
        chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 32'h208);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_size", mem_size, 2);
        resp(32'h12345678);
        chk("st_ov", out_valid, 1);
        chk("st_rob", out_rob, 5);
        chk("st_val", out_value, 0);
        step();
        rob_empty = 1;
        // CDB wakeup of a waiting head load
        enq(1, 3'd2, 32'h4, 0, 0, 1, 4'd7, 4'd8);
        step();
        chk("wk_wait", mem_req, 0);
        cdb_valid = 1; cdb_rob = 7; cdb_value = 32'h20;
        step();
        cdb_valid = 0;
        wait_req("wk_req");
        chk("wk_addr", mem_addr, 32'h24);
        resp(32'h11223344);
        chk("wk_val", out_value, 32'h11223344);
        chk("wk_rob", out_rob, 8);
        step();
        // load-to-load forwarding through the completion broadcast
        enq(1, 3'd2, 0, 32'h40, 0, 0, 0, 4'd9);
        enq(1, 3'd2, 32'h4, 0, 0, 1, 4'd9, 4'd10);
        chk("ld2_req", mem_req, 1);
        chk("ld2_addr", mem_addr, 32'h40);
        resp(32'h500);
        chk("ld2_gap", mem_req, 0);
        chk("ld2_ov", out_valid, 1);
        step();
        chk("ld2_next", mem_req, 1);
        chk("ld2_addr2", mem_addr, 32'h504);
        resp(0);
        chk("ld2_rob", out_rob, 10);
        step();
        // same-cycle bypass at enqueue
        cdb_valid = 1; cdb_rob = 11; cdb_value = 32'h300;
        put(1, 3'd2, 32'h8, 0, 0, 1, 4'd11, 4'd12);
        step();
        issue_valid = 0; issue_q1_busy = 0; cdb_valid = 0;
        wait_req("byp_req");
        chk("byp_addr", mem_addr, 32'h308);
        resp(0);
        step();
        // fill to capacity, overflow attempt, then drain in order
        for (int k = 0; k < 4; k++) begin
            enq(1, 3'd2, 32'(4 * k), 0, 0, 1, 4'd13, 4'(k + 1));
            chk("fill_cnt", count_out, 32'(k + 1));
            chk("fill_full", full_out, 32'(k >= 2));
        end
        enq(1, 3'd2, 0, 32'h7000, 0, 0, 0, 4'd15);
        chk("ovf_cnt", count_out, 4);
        cdb_valid = 1; cdb_rob = 13; cdb_value = 32'h1000;
        step();
        cdb_valid = 0;
        for (int k = 0; k < 4; k++) begin
            wait_req("drain_req");
            chk("drain_addr", mem_addr, 32'h1000 + 32'(4 * k));
            resp(32'(k));
            chk("drain_rob", out_rob, 32'(k + 1));
        end
        step(); step();
        chk("drain_cnt", count_out, 0);
        chk("drain_idle", mem_req, 0);
        enq(1, 3'd2, 0, 32'h50, 0, 0, 0, 4'd6);
        enq(1, 3'd2, 0, 32'h60, 0, 0, 0, 4'd7);
        wait_req("wrap_req1");
        chk("wrap_addr1", mem_addr, 32'h50);
        resp(0);
        wait_req("wrap_req2");
        chk("wrap_addr2", mem_addr, 32'h60);
        resp(0);
        chk("wrap_rob2", out_rob, 7);
        step();
        // flush with a load in flight
        enq(1, 3'd2, 0, 32'h70, 0, 0, 0, 4'd14);
        enq(1, 3'd2, 0, 0, 0, 1, 4'd15, 4'd3);
        chk("fl_req", mem_req, 1);
        chk("fl_cnt", count_out, 1);
        put(1, 3'd2, 0, 32'h80, 0, 0, 0, 4'd2);
        flush_in = 1;
        step();
        flush_in = 0; issue_valid = 0;
        chk("fl_cnt0", count_out, 0);
        chk("fl_hold", mem_req, 1);
        step();
        chk("fl_hold2", mem_req, 1);
        resp(32'hAB);
        chk("fl_done", mem_req, 0);
        chk("fl_silent", out_valid, 0);
        cdb_valid = 1; cdb_rob = 15; cdb_value = 0;
        step();
        cdb_valid = 0;
        step();
        chk("fl_empty", mem_req, 0);
        chk("fl_cnt_end", count_out, 0);
        // asynchronous reset mid-request
        enq(1, 3'd2, 0, 32'h90, 0, 0, 0, 4'd5);
        enq(1, 3'd2, 0, 0, 0, 1, 4'd15, 4'd6);
        chk("ar_req", mem_req, 1);
        rst_in = 1;
        #1;
        chk("ar_req0", mem_req, 0);
        chk("ar_ov0", out_valid, 0);
        chk("ar_cnt0", count_out, 0);
        chk("ar_full0", full_out, 0);
        step();
        rst_in = 0;
        step();
        // randomized traffic against the queue model
        outst = 0; exp_ov = 0; exp_rob = 0; exp_val = 0;
        for (int c = 0; c < 600; c++) begin
            rdy_in = $urandom_range(7) != 0;
            nxt.ld = 1'($urandom_range(1));
            nxt.f3 = nxt.ld ? 3'(lf3[$urandom_range(4)]) : 3'($urandom_range(2));
            v1r = $urandom; immr = $urandom;
            nxt.wd = $urandom; nxt.rob = 4'($urandom_range(15));
            nxt.addr = v1r + immr;
            put(nxt.ld, nxt.f3, immr, v1r, nxt.wd, 0, 0, nxt.rob);
            issue_valid = $urandom_range(2) == 0;
            rob_empty = pend.size() == 0;
            rob_head = pend.size() > 0 ? pend[0].rob : 4'd0;
            mem_done = rdy_in && outst && $urandom_range(1) == 0;
            mem_rdata = $urandom;
            drv_rdy = rdy_in;
            drv_done = mem_done;
            drv_enq = issue_valid && rdy_in && pend.size() < 4;
            disp_exp = rdy_in && !outst && pend.size() > 0;
            step();
            mem_done = 0;
            if (drv_rdy) begin
                exp_ov = drv_done;
                if (drv_done) begin
                    exp_rob = cur.rob;
                    exp_val = cur.ld ? load_val(cur.f3, mem_rdata) : 32'd0;
                    outst = 0;
                end
            end
            if (disp_exp) begin
                cur = pend.pop_front();
                outst = 1;
                chk("rnd_addr", mem_addr, cur.addr);
                chk("rnd_we", mem_we, !cur.ld);
                chk("rnd_size", mem_size, cur.f3[1:0]);
                if (!cur.ld) chk("rnd_wdata", mem_wdata, cur.wd);
            end
            if (drv_enq) pend.push_back(nxt);
            chk("rnd_req", mem_req, outst);
            chk("rnd_ov", out_valid, exp_ov);
            if (exp_ov) begin
                chk("rnd_rob", out_rob, exp_rob);
                chk("rnd_val", out_value, exp_val);
            end
            chk("rnd_cnt", count_out, pend.size());
            chk("rnd_full", full_out, pend.size() >= 3);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
